// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - data-memory port arbiter between MEM-stage pipeline and an aux requester
// DMEM_ARB_FAIRNESS_EN: defined enables bounded-wait forced aux grants; undefined gives strict pipeline priority
module dmem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_M,
  input  logic              MemWrite_M,
  input  logic [DATA_W-1:0] AluResult_M,
  input  logic [DATA_W-1:0] ReadData2_M,
  output logic              pipe_stall,
  output logic [DATA_W-1:0] pipe_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [DATA_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("dmem_port_arbiter: MAX_WAIT must be at least 1");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  logic              pipe_act;
  logic              aux_elig;
  logic              aux_grant;

  assign pipe_act = MemRead_M | MemWrite_M;
  // Ack is masked while reset is low so an interrupted ack cycle is never seen.
  assign aux_ack  = (state_q == S_ACK) & reset;
  assign aux_elig = aux_req & ~aux_ack;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  assign aux_grant  = reset & aux_elig & (~pipe_act | (wait_cnt_q == MAX_CNT));
  assign pipe_stall = pipe_act & aux_grant;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (aux_grant || !aux_req) begin
      wait_cnt_d = '0;
    end else if (aux_elig && (wait_cnt_q != MAX_CNT)) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign aux_grant  = reset & aux_elig & ~pipe_act;
  assign pipe_stall = 1'b0;
`endif

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (reset) begin
      if (aux_grant) begin
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
        mem_read  = ~aux_we;
        mem_write = aux_we;
      end else begin
        mem_addr  = AluResult_M;
        mem_wdata = ReadData2_M;
        mem_read  = MemRead_M;
        mem_write = MemWrite_M;
      end
    end
  end

  assign pipe_rdata = mem_rdata;
  assign aux_rdata  = aux_rdata_q;

  always_comb begin
    state_d     = (state_q == S_ACK) ? S_IDLE : state_q;
    aux_rdata_d = aux_rdata_q;
    if (aux_grant) begin
      state_d = S_ACK;
      if (!aux_we) begin
        aux_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        MemRead_M, MemWrite_M;
  logic [31:0] AluResult_M, ReadData2_M;
  logic        pipe_stall;
  logic [31:0] pipe_rdata;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wdata;
  logic        aux_ack;
  logic [31:0] aux_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(.DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .AluResult_M(AluResult_M), .ReadData2_M(ReadData2_M),
    .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b0;
    MemRead_M = 1'b0; MemWrite_M = 1'b1;
    AluResult_M = 32'h10; ReadData2_M = 32'hAAAA5555;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h10; aux_wdata = 32'h11111111;

    next_cycle(); next_cycle();
    sample();
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_pipe_stall", {31'b0, pipe_stall}, 32'd0);
    chk("rst_aux_ack", {31'b0, aux_ack}, 32'd0);
    chk("rst_aux_rdata", aux_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Release with both requesters active: the pipeline wins first.
    next_cycle();
    reset = 1'b1; MemWrite_M = 1'b0; MemRead_M = 1'b1; AluResult_M = 32'h20;
    aux_we = 1'b0;
    sample();
    chk("first_grant_addr", mem_addr, 32'h20);
    chk("first_grant_read", {31'b0, mem_read}, 32'd1);
    chk("first_grant_stall", {31'b0, pipe_stall}, 32'd0);

    next_cycle();
    MemRead_M = 1'b0; aux_req = 1'b0;
    next_cycle();

    // Aux write on an idle pipeline.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h10; aux_wdata = 32'hDEADBEEF;
    sample();
    chk("auxw_mem_write", {31'b0, mem_write}, 32'd1);
    chk("auxw_mem_addr", mem_addr, 32'h10);
    chk("auxw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("auxw_ack_early", {31'b0, aux_ack}, 32'd0);
    next_cycle();
    sample();
    chk("auxw_ack", {31'b0, aux_ack}, 32'd1);
    chk("auxw_no_regrant", {31'b0, mem_write}, 32'd0);
    next_cycle();
    aux_req = 1'b0;
    sample();
    chk("auxw_ack_pulse", {31'b0, aux_ack}, 32'd0);

    // Aux read of the same word.
    next_cycle();
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h10;
    sample();
    chk("auxr_mem_read", {31'b0, mem_read}, 32'd1);
    next_cycle();
    sample();
    chk("auxr_ack", {31'b0, aux_ack}, 32'd1);
    chk("auxr_rdata", aux_rdata, 32'hDEADBEEF);
    next_cycle();
    aux_req = 1'b0;
    sample();
    chk("auxr_rdata_held", aux_rdata, 32'hDEADBEEF);

    // Pipeline-only traffic: same-cycle read data, pipeline write then read back.
    next_cycle();
    MemRead_M = 1'b1; AluResult_M = 32'h10;
    sample();
    chk("pipe_rdata", pipe_rdata, 32'hDEADBEEF);
    chk("pipe_no_stall", {31'b0, pipe_stall}, 32'd0);
    next_cycle();
    MemRead_M = 1'b0; MemWrite_M = 1'b1; AluResult_M = 32'h14; ReadData2_M = 32'h12345678;
    sample();
    chk("pipe_mem_write", {31'b0, mem_write}, 32'd1);
    chk("pipe_wdata", mem_wdata, 32'h12345678);
    next_cycle();
    MemWrite_M = 1'b0; MemRead_M = 1'b1;
    sample();
    chk("pipe_readback", pipe_rdata, 32'h12345678);

    // Starvation: pipeline held busy, aux read of 0x10 requested.
    next_cycle();
    AluResult_M = 32'h20; aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h10;
`ifdef DMEM_ARB_FAIRNESS_EN
    for (int c = 1; c <= 4; c++) begin
      sample();
      chk($sformatf("starve_c%0d_stall", c), {31'b0, pipe_stall}, 32'd0);
      chk($sformatf("starve_c%0d_addr", c), mem_addr, 32'h20);
      next_cycle();
    end
    sample();
    chk("starve_c5_stall", {31'b0, pipe_stall}, 32'd1);
    chk("starve_c5_addr", mem_addr, 32'h10);
    next_cycle();
    sample();
    chk("starve_c6_ack", {31'b0, aux_ack}, 32'd1);
    chk("starve_c6_stall", {31'b0, pipe_stall}, 32'd0);
    chk("starve_c6_addr", mem_addr, 32'h20);
    chk("starve_c6_rdata", aux_rdata, 32'hDEADBEEF);
    next_cycle();
    aux_req = 1'b0;
`else
    for (int c = 1; c <= 6; c++) begin
      sample();
      chk($sformatf("strict_c%0d_stall", c), {31'b0, pipe_stall}, 32'd0);
      chk($sformatf("strict_c%0d_addr", c), mem_addr, 32'h20);
      chk($sformatf("strict_c%0d_ack", c), {31'b0, aux_ack}, 32'd0);
      next_cycle();
    end
    MemRead_M = 1'b0;
    sample();
    chk("strict_idle_grant", mem_addr, 32'h10);
    chk("strict_idle_read", {31'b0, mem_read}, 32'd1);
    next_cycle();
    sample();
    chk("strict_ack", {31'b0, aux_ack}, 32'd1);
    chk("strict_rdata", aux_rdata, 32'hDEADBEEF);
    next_cycle();
    aux_req = 1'b0; MemRead_M = 1'b1;
`endif

    // Abandoned request: 2 busy cycles, drop for 1, re-request.
    next_cycle();
    aux_req = 1'b1; aux_addr = 32'h14;
    next_cycle();
    next_cycle();
    aux_req = 1'b0;
    next_cycle();
    aux_req = 1'b1;
`ifdef DMEM_ARB_FAIRNESS_EN
    for (int c = 0; c < 4; c++) begin
      sample();
      chk($sformatf("abandon_r%0d_stall", c), {31'b0, pipe_stall}, 32'd0);
      next_cycle();
    end
    sample();
    chk("abandon_r4_stall", {31'b0, pipe_stall}, 32'd1);
    chk("abandon_r4_addr", mem_addr, 32'h14);
    next_cycle();
    sample();
    chk("abandon_ack", {31'b0, aux_ack}, 32'd1);
    chk("abandon_rdata", aux_rdata, 32'h12345678);
`else
    for (int c = 0; c < 5; c++) begin
      sample();
      chk($sformatf("abandon_strict_r%0d_addr", c), mem_addr, 32'h20);
      next_cycle();
    end
`endif
    next_cycle();
    aux_req = 1'b0; MemRead_M = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbiter and sequencer for the single-port data memory behind the MEM stage. It shares the memory between the pipeline (`MemRead_M`/`MemWrite_M`) and one auxiliary requester, such as a program loader or debug port. The pipeline has priority, and a bounded-wait counter guarantees the auxiliary port progress by stalling the pipeline for single cycles. The block sits between the MEM-stage control/data signals and the `Data_Memory` instance.

## Interface
Parameters:
- `DATA_W`, 32, data and address width.
- `MAX_WAIT`, 4, maximum number of consecutive cycles a pending aux request may lose to the pipeline. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (`reset==0` clears state at the next rising edge).
- `MemRead_M`  in  1  pipeline read request.
- `MemWrite_M`  in  1  pipeline write request.
- `AluResult_M`  in  DATA_W  pipeline address.
- `ReadData2_M`  in  DATA_W  pipeline write data.
- `pipe_stall`  out  1  pipeline must hold MEM stage this cycle.
- `pipe_rdata`  out  DATA_W  read data to pipeline.
- `aux_req`  in  1  aux request; held until `aux_ack`.
- `aux_we`  in  1  aux write (1) / read (0).
- `aux_addr`  in  DATA_W  aux address.
- `aux_wdata`  in  DATA_W  aux write data.
- `aux_ack`  out  1  one-cycle completion pulse.
- `aux_rdata`  out  DATA_W  registered aux read data, valid with `aux_ack` and held until the next aux read.
- `mem_addr`, `mem_wdata`  out  DATA_W  to memory.
- `mem_read`, `mem_write`  out  1  to memory.
- `mem_rdata`  in  DATA_W  combinational read data from memory.

## Operation
- `pipe_act = MemRead_M | MemWrite_M`.
- `aux_elig = aux_req & ~aux_ack`. A request is never eligible during its own ack cycle.
- States:
  - `S_IDLE`: normal arbitration.
  - `S_ACK`: aux access completed last cycle; `aux_ack=1`.
- Grant rule, evaluated each cycle:
  - Grant aux if `aux_elig & (~pipe_act | wait_cnt==MAX_WAIT)`.
  - Otherwise grant the pipeline.
- Pipeline grant:
  - Memory signals are a pass-through of the pipeline signals.
  - `pipe_rdata = mem_rdata`.
- Aux grant:
  - Memory signals come from `aux_*`, with `mem_read=~aux_we` and `mem_write=aux_we`.
  - At the clock edge, the write commits and the read value is latched into `aux_rdata`.
  - State moves to `S_ACK`.
- `pipe_stall = pipe_act & aux_grant`. A stall only occurs on a forced grant.
- `S_ACK` returns to `S_IDLE` unconditionally after one cycle. The pipeline may use memory during `S_ACK`.
- `wait_cnt`, width `$clog2(MAX_WAIT+1)`:
  - Increments, saturating at MAX_WAIT, when `aux_elig & ~aux_grant`.
  - Clears on aux grant.
  - Clears when `aux_req` drops without a grant (abandoned request).
- If `MemRead_M` and `MemWrite_M` are both asserted, both are passed through unchanged. This case is illegal upstream; no arbitration effect beyond `pipe_act`.

## Timing
- Reset (`reset==0` at an edge): state `S_IDLE`, `wait_cnt=0`, `aux_ack=0`, `aux_rdata=0`.
- While `reset==0`, combinational outputs are forced: `mem_read=0`, `mem_write=0`, `pipe_stall=0`, `mem_addr=0`, `mem_wdata=0`.
- Pipeline access has zero added latency. Read data arrives in the same cycle.
- Aux latency:
  - Granted in cycle N, `aux_ack` in cycle N+1.
  - Earliest next aux grant is N+2.
  - Idle-pipeline throughput is one aux access per 2 cycles.
- Worst-case aux latency from `aux_req` rise to `aux_ack` is MAX_WAIT+2 cycles.
- Stall rule: at most 1 stall cycle per aux access. Two stall cycles are never consecutive, because `S_ACK` blocks re-grant.
- Reset asserted in cycle N+1 (the ack cycle): `aux_ack` drops, the access already performed stands, and the requester re-issues.
- Simultaneous aux grant and pipeline write: the pipeline write is not performed; the pipeline holds via `pipe_stall` and retries the next cycle.

## Configuration
- `DMEM_ARB_FAIRNESS_EN` defined: bounded-wait behaviour as above.
- Not defined:
  - Strict pipeline priority; aux is granted only when `~pipe_act`.
  - `wait_cnt` is not instantiated and `pipe_stall` is tied 0.
  - Aux may starve indefinitely.

## Test plan
- Reset:
  - Drive `reset=0` with `MemWrite_M=1`, `aux_req=1` → `mem_write=0`, `pipe_stall=0`, `aux_ack=0`, `aux_rdata=0`.
  - After release → the first grant goes to the pipeline.
- Idle-pipeline aux write then read:
  - `aux_we=1`, addr 0x10, data 0xDEADBEEF → `mem_write` 1 cycle, `aux_ack` next cycle.
  - Read of 0x10 → `aux_rdata=0xDEADBEEF` with `aux_ack`.
- Pipeline-only traffic (`MemRead_M`, addr 0x10) → `pipe_rdata=0xDEADBEEF` same cycle, `pipe_stall` never 1.
- Starvation, MAX_WAIT=4: `pipe_act` held 1 and aux read request held →
  - Pipeline granted 4 cycles.
  - Cycle 5: `pipe_stall=1` and aux granted.
  - Cycle 6: `aux_ack=1`, `pipe_stall=0`.
- Abandoned request: `aux_req` for 2 busy cycles, then low for 1, then high again → `wait_cnt` restarts from 0; forced grant comes 4 cycles after the re-request.
- `DMEM_ARB_FAIRNESS_EN` undefined, same stimulus as the starvation test →
  - No stall and no aux grant while `pipe_act=1`.
  - Aux granted in the first cycle with `pipe_act=0`.
